// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   APB3 master bridge that sits behind the LSU command registers. A rising
//   edge on the CONTROL.en bit starts exactly one APB transfer to the slave
//   chosen by SEL. Read data, busy, done and error status go back to the LSU.
//
// Parameters
//   NUM_SLV  number of APB slaves (1..4); width of o_psel / i_pready / i_pslverr
//   TIMEOUT  ACCESS-phase wait limit in cycles (exists only with APB_TIMEOUT_EN)
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   : an ACCESS phase that sees no pready for TIMEOUT cycles is
//               aborted and reported as done + error
//   undefined : ACCESS waits for pready indefinitely
//
// Ports
//   i_clk, i_rst    clock, asynchronous active-low reset
//   i_paddr         command address        i_pwdata   command write data
//   i_sel           slave index            i_control  [0] en, [1] write(1)/read(0)
//   o_psel          one-hot slave select   o_penable  APB enable
//   o_pwrite        APB direction          o_paddr    APB address
//   o_pwdata        APB write data
//   i_prdata        per-slave read data, slave k at [32k+31:32k]
//   i_pready        per-slave ready        i_pslverr  per-slave error
//   o_rdata         captured read data     o_busy     transfer in progress
//   o_done          sticky: last transfer finished
//   o_err           sticky: last transfer ended in error
//
// States
//   IDLE   | no transfer; waiting for an en rising edge
//   SETUP  | APB setup phase: psel high, penable low (one cycle)
//   ACCESS | APB access phase: psel and penable high until pready (or timeout)

module apb_cmd_master #(
  parameter int NUM_SLV = 4
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4:0]            i_paddr,
  input  logic [31:0]           i_pwdata,
  input  logic [1:0]            i_sel,
  input  logic [1:0]            i_control,
  output logic [NUM_SLV-1:0]    o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [4:0]            o_paddr,
  output logic [31:0]           o_pwdata,
  input  logic [NUM_SLV*32-1:0] i_prdata,
  input  logic [NUM_SLV-1:0]    i_pready,
  input  logic [NUM_SLV-1:0]    i_pslverr,
  output logic [31:0]           o_rdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        en_prev;
  logic [1:0]  sel_q;
  logic        start;
  logic        sel_ok;
  logic        start_ok;
  logic        start_bad;

  logic        pready_sel;
  logic        pslverr_sel;
  logic [31:0] prdata_sel;
  logic        xfer_done;
  logic        abort;

  // en rising edge; only honoured from IDLE, but en_prev tracks every cycle so
  // an edge seen while busy is consumed rather than queued.
  assign start     = i_control[0] & ~en_prev;
  assign sel_ok    = ({30'd0, i_sel} < NUM_SLV);
  assign start_ok  = start & (state == IDLE) & sel_ok;
  assign start_bad = start & (state == IDLE) & ~sel_ok;

  // Only the latched slave's response is observed.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_q == 2'(k)) begin
        pready_sel  = i_pready[k];
        pslverr_sel = i_pslverr[k];
        prdata_sel  = i_prdata[32*k +: 32];
      end
    end
  end

  assign xfer_done = (state == ACCESS) & pready_sel;

`ifdef APB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wait_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready_sel) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th not-ready ACCESS cycle; a pready in that same
  // cycle takes priority and completes the transfer normally.
  assign abort = (state == ACCESS) & ~pready_sel & (wait_cnt == CntW'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus controls decode straight from the state so an async reset drops
  // psel/penable immediately.
  always_comb begin
    o_psel = '0;
    if (state != IDLE) begin
      for (int k = 0; k < NUM_SLV; k++) begin
        o_psel[k] = (sel_q == 2'(k));
      end
    end
  end

  assign o_penable = (state == ACCESS);
  assign o_busy    = (state != IDLE);

  // en_prev resets high so an en held across reset needs a fresh edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      en_prev  <= 1'b1;
      sel_q    <= '0;
      o_paddr  <= '0;
      o_pwdata <= '0;
      o_pwrite <= 1'b0;
      o_rdata  <= '0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      en_prev <= i_control[0];

      if (start_ok) begin
        sel_q    <= i_sel;
        o_paddr  <= i_paddr;
        o_pwdata <= i_pwdata;
        o_pwrite <= i_control[1];
        o_done   <= 1'b0;
        o_err    <= 1'b0;
      end

      // Out-of-range slave: report failure without touching the bus.
      if (start_bad) begin
        o_done <= 1'b1;
        o_err  <= 1'b1;
      end

      if (xfer_done) begin
        if (!o_pwrite) begin
          o_rdata <= prdata_sel;
        end
        o_err  <= pslverr_sel;
        o_done <= 1'b1;
      end else if (abort) begin
        o_err  <= 1'b1;
        o_done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB3 master bridge directly downstream of the LSU's memory-mapped APB command registers (PADDR 0x7900, PWDATA 0x7904, SEL 0x7908, CONTROL 0x790C).
- Turns a software write of CONTROL.en into exactly one APB transfer to the slave picked by SEL (e.g. the UART).
- Returns read data plus busy/done/error status for the LSU read-back path.

Parameters:
- NUM_SLV, 4: number of APB slaves; PSEL width. Legal range 1..4.
- TIMEOUT, 16: ACCESS-phase wait limit in cycles. Used only with APB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  async reset, active-low
- i_paddr  in  5  command address (LSU PADDR reg)
- i_pwdata  in  32  command write data (LSU PWDATA reg)
- i_sel  in  2  slave index (LSU SEL reg)
- i_control  in  2  [0] en (start request), [1] write(1)/read(0)
- o_psel  out  NUM_SLV  one-hot slave select
- o_penable  out  1  APB enable
- o_pwrite  out  1  APB direction
- o_paddr  out  5  APB address
- o_pwdata  out  32  APB write data
- i_prdata  in  NUM_SLV*32  per-slave read data, slave k at bits [32k+31:32k]
- i_pready  in  NUM_SLV  per-slave ready
- i_pslverr  in  NUM_SLV  per-slave error
- o_rdata  out  32  captured read data
- o_busy  out  1  transfer in progress
- o_done  out  1  sticky: last transfer finished
- o_err  out  1  sticky: last transfer ended in error

Behaviour:
- Reset (i_rst=0, async):
  - FSM goes to IDLE.
  - All outputs go to 0 immediately.
  - The en-history register is set to 1, so an en held high across reset does not start a transfer. Software must drop en and raise it again.
  - Reset mid-transfer aborts the transfer: PSEL and PENABLE drop at once, no completion is reported, o_rdata is cleared.
- Start event: i_control[0]=1 while en_prev=0, sampled at the clock edge. en_prev is updated every cycle.
- FSM IDLE:
  - On a start event, latch i_paddr, i_pwdata, i_sel and i_control[1] into internal copies.
  - Clear o_done and o_err, then go to SETUP.
  - If i_sel >= NUM_SLV: do not enter SETUP. Next cycle o_done=1 and o_err=1, no bus activity.
- FSM SETUP (1 cycle):
  - o_psel[sel]=1, o_penable=0.
  - o_paddr, o_pwdata, o_pwrite driven from the latched copies. Go to ACCESS.
- FSM ACCESS:
  - o_psel held, o_penable=1.
  - Stays while i_pready[sel]=0.
  - When i_pready[sel]=1, in the same cycle:
    - if read, o_rdata <= i_prdata[sel];
    - o_err <= i_pslverr[sel];
    - o_done <= 1;
    - go to IDLE.
  - On the next cycle o_psel=0 and o_penable=0.
- Latency: start edge at cycle N gives SETUP at N+1 and ACCESS at N+2. With zero wait states (pready=1 at N+2), o_done=1 at N+3. Each wait state adds 1 cycle.
- o_paddr, o_pwdata and o_pwrite come from the latched copies and stay stable across SETUP/ACCESS even if the LSU registers change. In IDLE they hold their last value.
- A start event while o_busy=1 is ignored and not queued. en_prev still tracks, so that edge is consumed.
- o_busy = (state != IDLE).
- o_rdata keeps its old value after a write transfer or an error.
- o_done and o_err stay set until the next accepted start or reset.
- Only the selected slave's pready, pslverr and prdata are observed. The other slaves' signals are don't-care.
- Back-to-back transfers: the earliest next start is the cycle after o_done rises (en low for ≥1 cycle, then high).

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT, the transfer aborts: go to IDLE, o_done=1, o_err=1, o_rdata unchanged, PSEL/PENABLE drop the next cycle.
  - A pready arriving in the same cycle the limit is hit wins: normal completion.
- Not defined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Write, zero wait: paddr=0x04, pwdata=0xA5A5_0055, sel=1, control 0b00→0b11, slave1 pready=1 -> psel=0b0010 at N+1 with penable=0; penable=1 at N+2 with paddr=0x04, pwdata=0xA5A50055, pwrite=1; o_done=1, o_err=0 at N+3.
- Read, 3 wait states: sel=2, control 0b01, slave2 prdata=0x0000_0041, pready at the 4th ACCESS cycle -> o_rdata=0x41 and o_done=1 at N+6; o_busy=1 for cycles N+1..N+5.
- Error plus ignored restart: slave0 pslverr=1 with pready; en toggled again mid-ACCESS -> o_err=1, exactly one transfer on the bus, second edge ignored.
- Reset: assert i_rst during ACCESS -> psel/penable=0 immediately; release with en still high -> no transfer until en goes 0 then 1.
- APB_TIMEOUT_EN, TIMEOUT=16, slave never ready -> abort after 16 ACCESS cycles with o_done=1, o_err=1, o_rdata unchanged.
- NUM_SLV=2, sel=3 -> no psel, o_done=1 and o_err=1 one cycle after the start edge.
